// File: rtl/qsfp_mgmt_ctrl_if.sv
// Wishbone register-port bundle shared by the interconnect and the QSFP+ management block.
interface wb_interface;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;

    modport slave  (input cyc, stb, we, adr, dat_i, output dat_o, ack);
    modport master (output cyc, stb, we, adr, dat_i, input dat_o, ack);
endinterface

// File: rtl/qsfp_mgmt_ctrl.sv
// QSFP+ management sequencer: insertion debounce, reset pulse, init wait, pin drive,
// plus a Wishbone register block with sticky events and a level interrupt.
module qsfp_mgmt_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned RESET_CYCLES    = 2000,
    parameter int unsigned INIT_CYCLES     = 400000000
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_interface.slave wb,
    input  logic       modprs_b_i,
    input  logic       int_b_i,
    output logic       modsel_b_o,
    output logic       reset_b_o,
    output logic       lp_mode_o,
    output logic       module_ready_o,
    output logic       irq_o
);

    typedef enum logic [2:0] {
        ST_ABSENT   = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_RESET    = 3'd2,
        ST_INIT     = 3'd3,
        ST_READY    = 3'd4
    } state_t;

    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RST_LAST  = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);

    logic [1:0]  prs_sync_q, int_sync_q;
    logic        intr_prev_q;
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [3:0]  events_q, events_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] rcnt_q, rcnt_d;
    logic        ack_q;
    logic [31:0] dat_q, dat_d;
    logic        reset_b_q, modsel_b_q, ready_q, irq_q;

    logic        prs, intr;
    logic        wb_req, wr;
    logic        soft_rst;
    logic [3:0]  evt_set;
    logic [31:0] rdata;
    logic        unused_dat;

    assign prs      = !prs_sync_q[1];
    assign intr     = !int_sync_q[1];
    assign wb_req   = wb.cyc && wb.stb && !ack_q;
    assign wr       = wb_req && wb.we;
    assign soft_rst = wr && (wb.adr == 8'h02) && wb.dat_i[0];
    assign unused_dat = ^wb.dat_i[31:4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        evt_set = '0;
        rcnt_d  = rcnt_q;
        // Removal beats every other transition, including a completing INIT.
        if (state_q != ST_ABSENT && !prs) begin
            state_d = ST_ABSENT;
            if (state_q != ST_DEBOUNCE) evt_set[1] = 1'b1;
        end else if (soft_rst && (state_q == ST_INIT || state_q == ST_READY)) begin
            state_d = ST_RESET;
        end else begin
            case (state_q)
                ST_ABSENT: if (prs) state_d = ST_DEBOUNCE;
                ST_DEBOUNCE: begin
                    if (cnt_q == DEB_LAST) begin
                        state_d    = ST_RESET;
                        evt_set[0] = 1'b1;
                    end
                end
                ST_RESET: if (cnt_q == RST_LAST) state_d = ST_INIT;
                ST_INIT: begin
                    if (cnt_q == INIT_LAST) begin
                        state_d    = ST_READY;
                        evt_set[3] = 1'b1;
                        rcnt_d     = rcnt_q + 16'd1;
                    end
                end
                ST_READY: state_d = ST_READY;
                default:  state_d = ST_ABSENT;
            endcase
        end
        if (state_d != state_q || state_q == ST_ABSENT || state_q == ST_READY) cnt_d = '0;
        if (state_q == ST_READY && intr && !intr_prev_q) evt_set[2] = 1'b1;

        ctrl_d = ctrl_q;
        if (wr && wb.adr == 8'h01) ctrl_d = wb.dat_i[1:0];
        mask_d = mask_q;
        if (wr && wb.adr == 8'h04) mask_d = wb.dat_i[3:0];
        events_d = events_q;
        if (wr && wb.adr == 8'h03) events_d = events_q & ~wb.dat_i[3:0];
        events_d = events_d | evt_set;

        case (wb.adr)
            8'h00:   rdata = {26'd0, (state_q == ST_READY), intr, prs, state_q};
            8'h01:   rdata = {30'd0, ctrl_q};
            8'h03:   rdata = {28'd0, events_q};
            8'h04:   rdata = {28'd0, mask_q};
            8'h05:   rdata = {16'd0, rcnt_q};
            default: rdata = '0;
        endcase
        dat_d = wb_req ? rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prs_sync_q  <= 2'b11;
            int_sync_q  <= 2'b11;
            intr_prev_q <= 1'b0;
            state_q     <= ST_ABSENT;
            cnt_q       <= '0;
            ctrl_q      <= 2'b10;
            events_q    <= '0;
            mask_q      <= '0;
            rcnt_q      <= '0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            reset_b_q   <= 1'b0;
            modsel_b_q  <= 1'b1;
            ready_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            prs_sync_q  <= {prs_sync_q[0], modprs_b_i};
            int_sync_q  <= {int_sync_q[0], int_b_i};
            intr_prev_q <= intr;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            events_q    <= events_d;
            mask_q      <= mask_d;
            rcnt_q      <= rcnt_d;
            ack_q       <= wb_req;
            dat_q       <= dat_d;
            // Pin outputs decode the next state so they move on the same edge as state.
            reset_b_q   <= (state_d == ST_INIT) || (state_d == ST_READY);
            modsel_b_q  <= !((state_d == ST_READY) && ctrl_d[1]);
            ready_q     <= (state_d == ST_READY);
            irq_q       <= |(events_q & mask_q);
        end
    end

    assign wb.ack         = ack_q;
    assign wb.dat_o       = dat_q;
    assign reset_b_o      = reset_b_q;
    assign modsel_b_o     = modsel_b_q;
    assign lp_mode_o      = ctrl_q[0];
    assign module_ready_o = ready_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_qsfp_mgmt_ctrl.sv
// Directed bench for qsfp_mgmt_ctrl with short timing parameters and a read-data scoreboard.
module tb_qsfp_mgmt_ctrl;

    logic clk = 1'b0;
    logic rst_n, modprs_b, int_b;
    logic modsel_b, reset_b, lp_mode, mready, irq;

    wb_interface wb_if ();

    qsfp_mgmt_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RESET_CYCLES   (8),
        .INIT_CYCLES    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb            (wb_if),
        .modprs_b_i    (modprs_b),
        .int_b_i       (int_b),
        .modsel_b_o    (modsel_b),
        .reset_b_o     (reset_b),
        .lp_mode_o     (lp_mode),
        .module_ready_o(mready),
        .irq_o         (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp);
        check(tag, 32'(dut.state_q), exp);
    endtask

    task automatic wb_xfer(input string tag, input logic we, input logic [7:0] adr,
                           input logic [31:0] wdat, input logic [31:0] exp);
        logic got;
        logic [31:0] e;
        if (!we) exp_q.push_back(exp);
        wb_if.cyc   = 1'b1;
        wb_if.stb   = 1'b1;
        wb_if.we    = we;
        wb_if.adr   = adr;
        wb_if.dat_i = wdat;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk);
            #1;
            got = wb_if.ack;
        end
        if (!got) check({tag, "_ack"}, 32'(wb_if.ack), 32'd1);
        if (!we) begin
            e = exp_q.pop_front();
            if (got) check(tag, wb_if.dat_o, e);
        end
        wb_if.cyc = 1'b0;
        wb_if.stb = 1'b0;
        wb_if.we  = 1'b0;
    endtask

    task automatic wb_read(input string tag, input logic [7:0] adr, input logic [31:0] exp);
        wb_xfer(tag, 1'b0, adr, 32'd0, exp);
    endtask

    task automatic wb_write(input string tag, input logic [7:0] adr, input logic [31:0] d);
        wb_xfer(tag, 1'b1, adr, d, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        rst_n = 1'b0; modprs_b = 1'b1; int_b = 1'b1;
        wb_if.cyc = 1'b0; wb_if.stb = 1'b0; wb_if.we = 1'b0;
        wb_if.adr = 8'd0; wb_if.dat_i = 32'd0;
        adv(3);
        rst_n = 1'b1;
        adv(2);
        check("rst_reset_b", 32'(reset_b), 32'd0);
        check("rst_modsel_b", 32'(modsel_b), 32'd1);
        check("rst_lp_mode", 32'(lp_mode), 32'd0);
        check("rst_ready", 32'(mready), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(wb_if.ack), 32'd0);
        check("rst_dat_o", wb_if.dat_o, 32'd0);
        wb_read("rst_status", 8'h00, 32'h00);
        wb_read("rst_control", 8'h01, 32'h02);
        wb_read("rst_command", 8'h02, 32'h00);
        wb_read("rst_events", 8'h03, 32'h00);
        wb_read("rst_mask", 8'h04, 32'h00);
        wb_read("rst_rcount", 8'h05, 32'h00);
        wb_read("unmapped_rd", 8'h40, 32'h00);
        wb_write("cmd_absent", 8'h02, 32'h1);
        adv(1);
        check_state("cmd_ignored_absent", 32'd0);

        // Short glitch on modprs_b: debounce entered then abandoned.
        modprs_b = 1'b0;
        adv(2);
        modprs_b = 1'b1;
        adv(1);
        check_state("glitch_debounce", 32'd1);
        adv(2);
        check_state("glitch_absent", 32'd0);
        check("glitch_reset_b", 32'(reset_b), 32'd0);
        adv(2);
        wb_read("glitch_events", 8'h03, 32'h0);

        // Full insertion at edge t.
        modprs_b = 1'b0;
        adv(2);
        check_state("ins_t2_absent", 32'd0);
        adv(1);
        check_state("ins_t3_debounce", 32'd1);
        adv(3);
        check_state("ins_t6_debounce", 32'd1);
        adv(1);
        check_state("ins_t7_reset", 32'd2);
        adv(7);
        check("ins_t14_reset_b", 32'(reset_b), 32'd0);
        adv(1);
        check("ins_t15_reset_b", 32'(reset_b), 32'd1);
        check_state("ins_t15_init", 32'd3);
        adv(15);
        check("ins_t30_ready", 32'(mready), 32'd0);
        adv(1);
        check("ins_t31_ready", 32'(mready), 32'd1);
        check("ins_t31_modsel_b", 32'(modsel_b), 32'd0);
        check_state("ins_t31_state", 32'd4);
        adv(2);
        check("ins_irq_masked", 32'(irq), 32'd0);
        wb_read("ins_events", 8'h03, 32'h9);
        wb_read("ins_rcount", 8'h05, 32'h1);
        wb_read("ins_status", 8'h00, 32'h2C);
        wb_write("ev_clear_all", 8'h03, 32'hF);
        wb_read("ev_cleared", 8'h03, 32'h0);

        wb_write("ctrl_lp", 8'h01, 32'h1);
        check("ctrl_lp_mode", 32'(lp_mode), 32'd1);
        check("ctrl_lp_modsel_b", 32'(modsel_b), 32'd1);
        wb_write("ctrl_sel", 8'h01, 32'h2);
        check("ctrl_sel_lp_mode", 32'(lp_mode), 32'd0);
        check("ctrl_sel_modsel_b", 32'(modsel_b), 32'd0);

        // Soft reset from READY.
        wb_write("soft_rst", 8'h02, 32'h1);
        check_state("soft_reset_state", 32'd2);
        check("soft_reset_b", 32'(reset_b), 32'd0);
        check("soft_ready", 32'(mready), 32'd0);
        check("soft_modsel_b", 32'(modsel_b), 32'd1);
        adv(7);
        check("soft_w7_reset_b", 32'(reset_b), 32'd0);
        adv(1);
        check("soft_w8_reset_b", 32'(reset_b), 32'd1);
        adv(15);
        check("soft_w23_ready", 32'(mready), 32'd0);
        adv(1);
        check("soft_w24_ready", 32'(mready), 32'd1);
        wb_read("soft_rcount", 8'h05, 32'h2);

        // Module interrupt.
        wb_write("mask_wr", 8'h04, 32'h4);
        wb_read("mask_rd", 8'h04, 32'h4);
        int_b = 1'b0;
        adv(3);
        check("int_k3_irq", 32'(irq), 32'd0);
        adv(1);
        check("int_k4_irq", 32'(irq), 32'd1);
        wb_read("int_events", 8'h03, 32'hC);
        wb_read("int_status", 8'h00, 32'h3C);
        wb_write("int_w1c", 8'h03, 32'h4);
        adv(1);
        check("int_w1c_irq", 32'(irq), 32'd0);
        wb_read("int_w1c_events", 8'h03, 32'h8);
        int_b = 1'b1;
        adv(4);
        int_b = 1'b0;
        adv(2);
        wb_write("int_w1c_race", 8'h03, 32'h4);
        adv(1);
        check("int_race_irq", 32'(irq), 32'd1);
        wb_read("int_race_events", 8'h03, 32'hC);

        // Held strobe: one ack every second cycle.
        wb_if.cyc = 1'b1; wb_if.stb = 1'b1; wb_if.we = 1'b0; wb_if.adr = 8'h05;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            adv(1);
            if (wb_if.ack) acks++;
        end
        wb_if.cyc = 1'b0; wb_if.stb = 1'b0;
        check("held_stb_acks", 32'(acks), 32'd3);

        // Removal during INIT.
        int_b = 1'b1;
        adv(4);
        wb_write("rm_clear", 8'h03, 32'hF);
        wb_write("rm_soft_rst", 8'h02, 32'h1);
        adv(8);
        check_state("rm_init", 32'd3);
        adv(2);
        modprs_b = 1'b1;
        adv(2);
        check_state("rm_r2_init", 32'd3);
        adv(1);
        check_state("rm_r3_absent", 32'd0);
        check("rm_reset_b", 32'(reset_b), 32'd0);
        check("rm_ready", 32'(mready), 32'd0);
        wb_read("rm_events", 8'h03, 32'h2);
        check("rm_irq", 32'(irq), 32'd0);

        // Asynchronous reset mid-sequence.
        modprs_b = 1'b0;
        wb_write("ar_ctrl", 8'h01, 32'h1);
        adv(8);
        check_state("ar_pre_reset", 32'd2);
        rst_n = 1'b0;
        #1;
        check_state("ar_state", 32'd0);
        check("ar_reset_b", 32'(reset_b), 32'd0);
        check("ar_lp_mode", 32'(lp_mode), 32'd0);
        check("ar_modsel_b", 32'(modsel_b), 32'd1);
        check("ar_irq", 32'(irq), 32'd0);
        adv(2);
        rst_n = 1'b1;
        adv(2);
        check_state("ar_e2_absent", 32'd0);
        adv(1);
        check_state("ar_e3_debounce", 32'd1);
        wb_read("ar_control", 8'h01, 32'h2);
        wb_read("ar_events", 8'h03, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qsfp_mgmt_ctrl.md
# qsfp_mgmt_ctrl

Autonomous QSFP+ module management sequencer. It sits beside the QSFP+ port transceiver and I2C master in `sys_clk`. It debounces module insertion, applies the power-up reset pulse and initialisation wait, and drives the `modsel_b`, `reset_b` and `lp_mode` pins. Status, sticky events and an interrupt are exposed on a Wishbone slave attached to one `wb_array` slot of the interconnect.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 20000: cycles `modprs` must stay asserted before the module is accepted; ≥1.
- `RESET_CYCLES`, 2000: `reset_b` low pulse length after debounce; ≥1.
- `INIT_CYCLES`, 400000000: wait after `reset_b` release before the module is declared ready; ≥1; fits the 32-bit counter.

Ports:
- `clk`  in  1  single clock (`sys_clk`); all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `wb`  slave  `wb_interface`  register access (`cyc`, `stb`, `we`, `adr`, `dat_i`, `dat_o`, `ack`); word address `adr[7:0]`.
- `modprs_b_i`  in  1  module present, active-low, asynchronous.
- `int_b_i`  in  1  module interrupt, active-low, asynchronous.
- `modsel_b_o`  out  1  module select, active-low.
- `reset_b_o`  out  1  module reset, active-low.
- `lp_mode_o`  out  1  low-power mode.
- `module_ready_o`  out  1  high in READY.
- `irq_o`  out  1  level interrupt, `|(EVENTS & IRQ_MASK)`.

## Operation
- `modprs_b_i` and `int_b_i` each pass through a 2-FF synchroniser. Internal `prs = !modprs_b_sync` and `intr = !int_b_sync`.
- A 32-bit counter clears on every state entry and increments each cycle in a timed state. The state exits when `counter == N-1`, so it lasts exactly N cycles.
- ABSENT (reset state): on `prs`, go to DEBOUNCE.
- DEBOUNCE: if `!prs`, return to ABSENT with no event. After `DEBOUNCE_CYCLES`, go to RESET and set EVENTS[0] (inserted).
- RESET: after `RESET_CYCLES`, go to INIT.
- INIT: after `INIT_CYCLES`, go to READY. Set EVENTS[3] (ready) and increment READY_COUNT (16-bit, wraps).
- From DEBOUNCE, RESET, INIT or READY:
  - If `!prs`, go to ABSENT next cycle. Set EVENTS[1] (removed), except when leaving DEBOUNCE.
  - Removal has priority over every other transition.
- Soft reset: COMMAND write with bit0=1 while in INIT or READY forces RESET. The write is ignored in other states.
- Output decoding:
  - `reset_b_o = 0` in ABSENT, DEBOUNCE and RESET; `1` in INIT and READY.
  - `modsel_b_o = !(READY && CONTROL[1])`.
  - `lp_mode_o = CONTROL[0]`.
  - `module_ready_o = (state == READY)`.
- EVENTS[2] (interrupt): set on a rising edge of `intr` while in READY.
- Registers (state encoding: ABSENT=0, DEBOUNCE=1, RESET=2, INIT=3, READY=4):
  - 0x00 STATUS, RO: [2:0] state, [3] `prs`, [4] `intr`, [5] ready.
  - 0x01 CONTROL, RW: [0] `lp_mode` (reset 0), [1] `sel_en` (reset 1).
  - 0x02 COMMAND, WO: [0] soft reset; reads return 0.
  - 0x03 EVENTS, RO sticky, write-1-to-clear: [3:0].
  - 0x04 IRQ_MASK, RW [3:0], reset 0.
  - 0x05 READY_COUNT, RO [15:0], reset 0.
  - Unmapped addresses: reads return 0, writes are ignored.
- Simultaneous event set and W1C of the same bit: set wins.

## Timing
- Reset values:
  - state ABSENT, counter 0.
  - `reset_b_o = 0`, `modsel_b_o = 1`, `lp_mode_o = 0`, `module_ready_o = 0`, `irq_o = 0`.
  - `wb.ack = 0`, `wb.dat_o = 0`.
  - All registers at their listed reset values.
- Pin latency: a pin change at edge k is visible synchronised at k+2. The state changes at k+3. Outputs are registered decodes of state and change in the same cycle as state.
- Wishbone:
  - `ack` is asserted the cycle after `cyc & stb` is sampled with `ack` low, and stays high for exactly one cycle.
  - `dat_o` is valid with `ack`.
  - Writes take effect on the `ack` cycle.
  - A held `stb` produces one `ack` every second cycle; there is never a double ack.
- `irq_o` is registered: one cycle after the EVENTS/IRQ_MASK change.
- Reset asserted mid-sequence: immediate return to reset values. After release the sequence restarts from ABSENT, including full debounce.

## Test plan
Use `DEBOUNCE_CYCLES=4`, `RESET_CYCLES=8`, `INIT_CYCLES=16`.
- Release `rst_n` with `modprs_b_i=1` → STATUS=0x00, `reset_b_o=0`, `modsel_b_o=1`, `lp_mode_o=0`, `irq_o=0`.
- `modprs_b_i` falls at edge t:
  - DEBOUNCE at t+3, RESET at t+7, `reset_b_o` rises at t+15, READY at t+31.
  - Then `modsel_b_o=0`, EVENTS=0x9, READY_COUNT=1.
- `modprs_b_i` low for 2 cycles then high → DEBOUNCE then ABSENT, EVENTS=0, `reset_b_o` stays 0.
- Remove the module during INIT → ABSENT 3 cycles after the pin edge, EVENTS[1]=1, `reset_b_o=0`, `module_ready_o=0`.
- In READY:
  - Write CONTROL=0x1 → `lp_mode_o=1`, `modsel_b_o=1`.
  - Write COMMAND=0x1 → RESET for 8 cycles, INIT, READY again, READY_COUNT=2.
- IRQ_MASK=0x4, `int_b_i` falls in READY:
  - `irq_o=1` four cycles after the pin edge.
  - W1C EVENTS=0x4 → `irq_o=0`.
  - Repeat the W1C on the same cycle as a new `intr` edge → bit stays set.
